optical_flow_stream_out: RTL and testbench

OPTICAL_FLOW_STREAM_OUT -- requirements
Module: optical_flow_stream_out

---
 rtl/optical_flow_stream_out.sv | 210 +++++++++++++++++++++
 tb/tb_optical_flow_stream_out.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/optical_flow_stream_out.sv
// ---------------------------------------------------------------------------
// optical_flow_stream_out
//
// Tags each incoming optical-flow sample (u,v) with its pixel coordinate and
// frame markers (start-of-frame, end-of-line, end-of-frame), buffers it in a
// small FIFO and presents it on a valid/ready output stream. Upstream has no
// backpressure, so a sample arriving while the FIFO is full (and not being
// drained that same cycle) is dropped and counted.
//
// Optional feature macro: FLOW_CLAMP_EN
//   defined   -> u/v saturated to [-CLAMP_LIMIT, +CLAMP_LIMIT] before buffering
//   undefined -> u/v passed through unchanged
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   frame_start              starts a frame (only honoured while idle)
//   flow_u, flow_v           signed flow components
//   flow_valid               sample strobe
//   m_valid/m_ready          output handshake
//   m_u, m_v, m_x, m_y       buffered sample and its column/row
//   m_sof, m_eol, m_eof      frame markers of the buffered sample
//   busy                     frame in progress or still draining
//   frame_done               one-cycle pulse when the frame has fully drained
//   overflow                 sticky flag: at least one sample was dropped
//   drop_count               saturating count of dropped samples
// ---------------------------------------------------------------------------
module optical_flow_stream_out #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int FLOW_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLAMP_LIMIT  = 2047
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic signed [FLOW_WIDTH-1:0] flow_u,
    input  logic signed [FLOW_WIDTH-1:0] flow_v,
    input  logic                         flow_valid,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [FLOW_WIDTH-1:0] m_u,
    output logic signed [FLOW_WIDTH-1:0] m_v,
    output logic [9:0]                   m_x,
    output logic [8:0]                   m_y,
    output logic                         m_sof,
    output logic                         m_eol,
    output logic                         m_eof,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overflow,
    output logic [15:0]                  drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [9:0]  X_LAST  = 10'(IMAGE_WIDTH - 1);
    localparam logic [8:0]  Y_LAST  = 9'(IMAGE_HEIGHT - 1);

    // A clamp limit that does not fit the flow width would make saturation meaningless.
    if (CLAMP_LIMIT <= 0 || CLAMP_LIMIT >= (1 << (FLOW_WIDTH - 1))) begin : gBadClamp
        $error("CLAMP_LIMIT out of range for FLOW_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    typedef struct packed {
        logic signed [FLOW_WIDTH-1:0] u;
        logic signed [FLOW_WIDTH-1:0] v;
        logic [9:0]                   x;
        logic [8:0]                   y;
        logic                         sof;
        logic                         eol;
        logic                         eof;
    } entry_t;

    state_t         state_q, state_d;
    logic [9:0]     x_q;
    logic [8:0]     y_q;
    logic [AW-1:0]  wr_q, rd_q;
    logic [AW:0]    count_q;
    logic           overflow_q;
    logic [15:0]    drop_q;
    entry_t         mem_q [FIFO_DEPTH];

    logic           accept, full, pop, push, drop;
    logic           tagEol, tagEof;
    logic signed [FLOW_WIDTH-1:0] inU, inV;
    entry_t         newEntry, head;

`ifdef FLOW_CLAMP_EN
    localparam logic signed [FLOW_WIDTH-1:0] CLAMP_C = FLOW_WIDTH'(CLAMP_LIMIT);

    function automatic logic signed [FLOW_WIDTH-1:0] clampFlow(input logic signed [FLOW_WIDTH-1:0] val);
        if (val > CLAMP_C)
            return CLAMP_C;
        else if (val < -CLAMP_C)
            return -CLAMP_C;
        else
            return val;
    endfunction

    assign inU = clampFlow(flow_u);
    assign inV = clampFlow(flow_v);
`else
    assign inU = flow_u;
    assign inV = flow_v;
`endif

    // Samples only count while a frame is active; the handshake pop frees a slot
    // in the same cycle, so a full FIFO can still take a sample when draining.
    assign accept = (state_q == ACTIVE) && flow_valid;
    assign full   = (count_q == DEPTH_C);
    assign pop    = m_valid && m_ready;
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;

    assign tagEol = (x_q == X_LAST);
    assign tagEof = tagEol && (y_q == Y_LAST);

    assign newEntry = '{u: inU, v: inV, x: x_q, y: y_q,
                        sof: (x_q == 10'd0) && (y_q == 9'd0),
                        eol: tagEol, eof: tagEof};

    // Outputs read as zero whenever nothing is buffered.
    assign m_valid = (count_q != '0);
    assign head    = m_valid ? mem_q[rd_q] : '0;
    assign m_u     = head.u;
    assign m_v     = head.v;
    assign m_x     = head.x;
    assign m_y     = head.y;
    assign m_sof   = head.sof;
    assign m_eol   = head.eol;
    assign m_eof   = head.eof;

    assign overflow   = overflow_q;
    assign drop_count = drop_q;

    // Next-state logic: the end-of-frame sample moves to DRAIN even when it was
    // dropped, and the frame only completes once every buffered sample is out.
    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE:   if (frame_start) state_d = ACTIVE;
            ACTIVE: if (accept && tagEof) state_d = DRAIN;
            DRAIN: begin
                if (count_q == '0) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, coordinate counters, FIFO bookkeeping and drop statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && frame_start) begin
                x_q        <= '0;
                y_q        <= '0;
                overflow_q <= 1'b0;
                drop_q     <= '0;
            end

            // Coordinates advance for every accepted sample, dropped or not.
            if (accept) begin
                if (tagEol) begin
                    x_q <= '0;
                    y_q <= (y_q == Y_LAST) ? 9'd0 : y_q + 9'd1;
                end else begin
                    x_q <= x_q + 10'd1;
                end
            end

            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != 16'hFFFF)
                    drop_q <= drop_q + 16'd1;
            end

            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q] <= newEntry;
    end

endmodule

// File: tb/tb_optical_flow_stream_out.sv
// ---------------------------------------------------------------------------
// tb_optical_flow_stream_out
//
// Directed bench for optical_flow_stream_out with a 4x2 image and a 4-entry
// FIFO. Inputs change on the falling edge; outputs are sampled on the
// falling edge, half a period away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_optical_flow_stream_out;

    logic               clk = 1'b0;
    logic               rst;
    logic               frame_start;
    logic signed [15:0] flow_u, flow_v;
    logic               flow_valid;
    logic               m_valid, m_ready;
    logic signed [15:0] m_u, m_v;
    logic [9:0]         m_x;
    logic [8:0]         m_y;
    logic               m_sof, m_eol, m_eof;
    logic               busy, frame_done, overflow;
    logic [15:0]        drop_count;

    int passCount  = 0;
    int checkCount = 0;

    optical_flow_stream_out #(
        .IMAGE_WIDTH (4),
        .IMAGE_HEIGHT(2),
        .FLOW_WIDTH  (16),
        .FIFO_DEPTH  (4),
        .CLAMP_LIMIT (2047)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .flow_u     (flow_u),
        .flow_v     (flow_v),
        .flow_valid (flow_valid),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_u        (m_u),
        .m_v        (m_v),
        .m_x        (m_x),
        .m_y        (m_y),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .m_eof      (m_eof),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Hold reset for two edges with all inputs quiet, release on a falling edge.
    task automatic doReset();
        rst         = 1'b1;
        frame_start = 1'b0;
        flow_valid  = 1'b0;
        flow_u      = '0;
        flow_v      = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One-cycle frame_start pulse; returns with the DUT in ACTIVE.
    task automatic startFrame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [72:0] got;
        doReset();
        got = {m_valid, busy, frame_done, overflow, drop_count, m_u, m_v, m_x, m_y, m_sof, m_eol, m_eof};
        checkCount++;
        if (got !== '0) $display("[TB] FAIL reset_state: got %h expected 0", got);
        else passCount++;

        // Samples are ignored while idle.
        m_ready    = 1'b0;
        flow_valid = 1'b1;
        flow_u     = 16'sd5;
        @(negedge clk);
        flow_valid = 1'b0;
        checkCount++;
        if ({m_valid, busy} !== 2'b00) $display("[TB] FAIL idle_ignore: valid/busy %b expected 00", {m_valid, busy});
        else passCount++;
    endtask

    task automatic test_frame();
        logic [55:0] got, exp;
        doReset();
        m_ready = 1'b1;
        startFrame();
        checkCount++;
        if (busy !== 1'b1) $display("[TB] FAIL frame_busy: got %b expected 1", busy);
        else passCount++;
        for (int i = 0; i < 8; i++) begin
            flow_valid = 1'b1;
            flow_u     = 16'(100 + i);
            flow_v     = -16'(i + 1);
            @(negedge clk);
            got = {m_valid, m_x, m_y, m_sof, m_eol, m_eof, m_u, m_v};
            exp = {1'b1, 10'(i % 4), 9'(i / 4), (i == 0), (i % 4 == 3), (i == 7), 16'(100 + i), -16'(i + 1)};
            checkCount++;
            if (got !== exp) $display("[TB] FAIL frame_sample%0d: got %h expected %h", i, got, exp);
            else passCount++;
        end
        flow_valid = 1'b0;
        checkCount++;
        if (frame_done !== 1'b0) $display("[TB] FAIL frame_done_early: got %b expected 0", frame_done);
        else passCount++;
        @(negedge clk);
        checkCount++;
        if ({frame_done, m_valid, busy} !== 3'b101)
            $display("[TB] FAIL frame_done_pulse: done/valid/busy %b expected 101", {frame_done, m_valid, busy});
        else passCount++;
        @(negedge clk);
        checkCount++;
        if ({frame_done, busy} !== 2'b00) $display("[TB] FAIL frame_idle: done/busy %b expected 00", {frame_done, busy});
        else passCount++;
    endtask

    task automatic test_overflow();
        doReset();
        m_ready = 1'b0;
        startFrame();
        for (int i = 0; i < 6; i++) begin
            flow_valid = 1'b1;
            flow_u     = 16'(i);
            flow_v     = '0;
            @(negedge clk);
        end
        flow_valid = 1'b0;
        checkCount++;
        if ({overflow, drop_count} !== {1'b1, 16'd2})
            $display("[TB] FAIL ovf_flags: overflow %b drop %0d expected 1 and 2", overflow, drop_count);
        else passCount++;
        checkCount++;
        if ({m_valid, m_x, m_u} !== {1'b1, 10'd0, 16'sd0})
            $display("[TB] FAIL ovf_hold: valid %b x %0d u %0d expected 1 0 0", m_valid, m_x, m_u);
        else passCount++;
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkCount++;
            if ({m_valid, m_x, m_y, m_u} !== {1'b1, 10'(k), 9'd0, 16'(k)})
                $display("[TB] FAIL ovf_out%0d: valid %b x %0d y %0d u %0d expected 1 %0d 0 %0d", k, m_valid, m_x, m_y, m_u, k, k);
            else passCount++;
            @(negedge clk);
        end
        checkCount++;
        if ({m_valid, overflow} !== 2'b01) $display("[TB] FAIL ovf_empty: valid/overflow %b expected 01", {m_valid, overflow});
        else passCount++;
    endtask

    task automatic test_full_push_pop();
        int pops = 0;
        doReset();
        m_ready = 1'b0;
        startFrame();
        for (int i = 0; i < 4; i++) begin
            flow_valid = 1'b1;
            flow_u     = 16'(10 + i);
            @(negedge clk);
        end
        // FIFO full: push and pop on the same edge.
        flow_u  = 16'sd14;
        m_ready = 1'b1;
        @(negedge clk);
        flow_valid = 1'b0;
        m_ready    = 1'b0;
        checkCount++;
        if ({overflow, drop_count, m_x, m_u} !== {1'b0, 16'd0, 10'd1, 16'sd11})
            $display("[TB] FAIL full_pp: overflow %b drop %0d x %0d u %0d expected 0 0 1 11", overflow, drop_count, m_x, m_u);
        else passCount++;
        m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (m_valid) begin
                checkCount++;
                if ({m_x, m_y, m_u} !== {10'((pops + 1) % 4), 9'(pops == 3), 16'(11 + pops)})
                    $display("[TB] FAIL full_drain%0d: x %0d y %0d u %0d expected %0d %0d %0d", pops, m_x, m_y, m_u, (pops + 1) % 4, pops == 3, 11 + pops);
                else passCount++;
                pops++;
            end
            @(negedge clk);
        end
        checkCount++;
        if (pops !== 4) $display("[TB] FAIL full_occupancy: got %0d entries expected 4", pops);
        else passCount++;
    endtask

    task automatic test_clamp();
        logic signed [15:0] expU, expV;
`ifdef FLOW_CLAMP_EN
        expU = 16'sd2047;
        expV = -16'sd2047;
`else
        expU = 16'sd3000;
        expV = -16'sd3000;
`endif
        doReset();
        m_ready = 1'b0;
        startFrame();
        flow_valid = 1'b1;
        flow_u     = 16'sd3000;
        flow_v     = -16'sd3000;
        @(negedge clk);
        flow_valid = 1'b0;
        checkCount++;
        if ({m_u, m_v} !== {expU, expV})
            $display("[TB] FAIL clamp_uv: got %0d %0d expected %0d %0d", m_u, m_v, expU, expV);
        else passCount++;
    endtask

    task automatic test_midframe_reset();
        int doneSeen = 0;
        doReset();
        m_ready = 1'b0;
        startFrame();
        for (int i = 0; i < 3; i++) begin
            flow_valid = 1'b1;
            flow_u     = 16'(i);
            @(negedge clk);
        end
        flow_valid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkCount++;
        if ({m_valid, busy, frame_done} !== 3'b000)
            $display("[TB] FAIL mid_reset: valid/busy/done %b expected 000", {m_valid, busy, frame_done});
        else passCount++;
        for (int c = 0; c < 4; c++) begin
            if (frame_done) doneSeen++;
            @(negedge clk);
        end
        checkCount++;
        if (doneSeen !== 0) $display("[TB] FAIL mid_no_done: got %0d pulses expected 0", doneSeen);
        else passCount++;
        m_ready = 1'b1;
        startFrame();
        flow_valid = 1'b1;
        flow_u     = 16'sd7;
        @(negedge clk);
        flow_valid = 1'b0;
        checkCount++;
        if ({m_valid, m_x, m_y, m_sof, m_u} !== {1'b1, 10'd0, 9'd0, 1'b1, 16'sd7})
            $display("[TB] FAIL mid_restart: valid %b x %0d y %0d sof %b u %0d expected 1 0 0 1 7", m_valid, m_x, m_y, m_sof, m_u);
        else passCount++;
    endtask

    task automatic test_frame_start_ignored();
        doReset();
        m_ready = 1'b1;
        startFrame();
        for (int i = 0; i < 4; i++) begin
            flow_valid  = 1'b1;
            frame_start = (i == 2);
            flow_u      = 16'(i);
            @(negedge clk);
            checkCount++;
            if ({m_x, m_y, m_sof, m_eol, busy} !== {10'(i), 9'd0, (i == 0), (i == 3), 1'b1})
                $display("[TB] FAIL fs_ignore%0d: x %0d y %0d sof %b eol %b busy %b expected %0d 0 %0d %0d 1", i, m_x, m_y, m_sof, m_eol, busy, i, i == 0, i == 3);
            else passCount++;
        end
        frame_start = 1'b0;
        flow_valid  = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        flow_valid  = 1'b0;
        flow_u      = '0;
        flow_v      = '0;
        m_ready     = 1'b0;
        test_reset();
        test_frame();
        test_overflow();
        test_full_push_pop();
        test_clamp();
        test_midframe_reset();
        test_frame_start_ignored();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
